// File: rtl/mips_muldiv_seq_if.sv
// mips_muldiv_seq_if: ALU operand/result bundle; the sequencer is master, the ALU slave.
interface mips_muldiv_seq_if #(parameter int XLEN = 32);
  logic [3:0]      alu_ctl;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_out;
  logic            alu_zero;
  logic            alu_ovf;
  modport master(output alu_ctl, alu_a, alu_b, input alu_out, alu_zero, alu_ovf);
  modport slave(input alu_ctl, alu_a, alu_b, output alu_out, alu_zero, alu_ovf);
endinterface

// File: rtl/mips_muldiv_seq.sv
// mips_muldiv_seq: multicycle HI/LO MULTU/DIVU sequencer, one shared-ALU add/sub per iteration.
// Define MULDIV_SIGNED_EN to make op 10/11 signed MULT/DIV via sign fix-up around the unsigned core.
module mips_muldiv_seq #(parameter int XLEN = 32) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [XLEN-1:0]   rs_val,
  input  logic [XLEN-1:0]   rt_val,
  output logic              busy,
  output logic              done,
  output logic [XLEN-1:0]   hi,
  output logic [XLEN-1:0]   lo,
  mips_muldiv_seq_if.master alu
);
  localparam logic [3:0] ADD = 4'b0010, SUB = 4'b0110, NOR = 4'b1100;
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CMAX = CW'(XLEN - 1);
  typedef enum logic [2:0] {IDLE, ITER, DONE, PREP1, PREP2, FIX1, FIX2} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] p_hi, p_lo, b_reg, np_hi, np_lo, h_s;
  logic mul, dz, dz0, msb, a_m, b_m, s_m, cy, q, fix;
  assign dz0 = op[0] && rt_val == '0;
  assign msb = p_hi[XLEN-1];
  assign h_s = {p_hi[XLEN-2:0], p_lo[XLEN-1]};
  assign a_m = alu.alu_a[XLEN-1];
  assign b_m = alu.alu_b[XLEN-1];
  assign s_m = alu.alu_out[XLEN-1];
  // unsigned carry / no-borrow rebuilt from MSBs since the ALU exposes only signed overflow
  assign cy = (a_m & b_m) | ((a_m | b_m) & ~s_m);
  assign q = msb | (a_m & ~b_m) | ((a_m | ~b_m) & ~s_m);
`ifdef MULDIV_SIGNED_EN
  logic sa, sb, sgn, lz;
  logic unused;
  assign unused = alu.alu_ovf;
  assign fix = sgn && !dz;
`else
  logic unused;
  assign unused = ^{op[1], alu.alu_zero, alu.alu_ovf};
  assign fix = 1'b0;
`endif
  always_comb begin
    alu.alu_ctl = ADD;
    alu.alu_a = '0;
    alu.alu_b = '0;
    if (state == ITER && !dz) begin
      alu.alu_ctl = mul ? ADD : SUB;
      alu.alu_a = mul ? p_hi : h_s;
      alu.alu_b = b_reg;
    end
`ifdef MULDIV_SIGNED_EN
    if (state == PREP1 || state == FIX1) begin
      alu.alu_ctl = SUB;
      alu.alu_b = p_lo;
    end
    if (state == PREP2) begin
      alu.alu_ctl = SUB;
      alu.alu_b = b_reg;
    end
    if (state == FIX2) begin
      alu.alu_ctl = (mul && !lz) ? NOR : SUB;
      alu.alu_a = (mul && !lz) ? p_hi : '0;
      alu.alu_b = p_hi;
    end
`endif
  end
  always_comb begin
    np_hi = p_hi;
    np_lo = p_lo;
    if (state == ITER && !dz) begin
      np_hi = mul ? (p_lo[0] ? {cy, alu.alu_out[XLEN-1:1]} : {1'b0, p_hi[XLEN-1:1]}) : (q ? alu.alu_out : h_s);
      np_lo = mul ? {p_lo[0] ? alu.alu_out[0] : p_hi[0], p_lo[XLEN-1:1]} : {p_lo[XLEN-2:0], q};
    end
`ifdef MULDIV_SIGNED_EN
    if ((state == PREP1 && sa) || (state == FIX1 && (sa ^ sb))) np_lo = alu.alu_out;
    if (state == FIX2 && (mul ? sa ^ sb : sa)) np_hi = alu.alu_out;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      p_hi <= '0;
      p_lo <= '0;
      b_reg <= '0;
      mul <= 1'b0;
      dz <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      hi <= '0;
      lo <= '0;
`ifdef MULDIV_SIGNED_EN
      sa <= 1'b0;
      sb <= 1'b0;
      sgn <= 1'b0;
      lz <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      p_hi <= np_hi;
      p_lo <= np_lo;
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          mul <= ~op[0];
          dz <= dz0;
          b_reg <= rt_val;
          p_hi <= dz0 ? rs_val : '0;
          p_lo <= dz0 ? '1 : rs_val;
          cnt <= dz0 ? CMAX : '0;
`ifdef MULDIV_SIGNED_EN
          sgn <= op[1];
          sa <= op[1] & rs_val[XLEN-1];
          sb <= op[1] & rt_val[XLEN-1];
          state <= (op[1] && !dz0) ? PREP1 : ITER;
`else
          state <= ITER;
`endif
        end
        ITER: begin
          cnt <= cnt == CMAX ? '0 : cnt + 1'b1;
          if (cnt == CMAX) begin
            state <= fix ? FIX1 : DONE;
            done <= !fix;
            if (!fix) begin
              hi <= np_hi;
              lo <= np_lo;
            end
          end
        end
`ifdef MULDIV_SIGNED_EN
        PREP1: state <= PREP2;
        PREP2: begin
          b_reg <= sb ? alu.alu_out : b_reg;
          state <= ITER;
        end
        FIX1: begin
          lz <= alu.alu_zero;
          state <= FIX2;
        end
        FIX2: begin
          state <= DONE;
          done <= 1'b1;
          hi <= np_hi;
          lo <= np_lo;
        end
`endif
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/mips_muldiv_seq.md
Name: mips_muldiv_seq

Overview:
- Multicycle HI/LO multiply/divide sequencer for the MIPS datapath.
- Acts as the initiator on the ALU interface: drives alu_ctl, alu_a and alu_b each cycle, and consumes alu_out and alu_zero.
- Performs MULTU/DIVU with one ALU add or subtract per iteration. HI/LO are updated only at completion.

Parameters:
- XLEN, 32, operand width; the iteration count equals XLEN.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request pulse; sampled only in IDLE
- op  in  2  00 MULTU, 01 DIVU, 10 MULT, 11 DIV
- rs_val  in  XLEN  multiplicand / dividend
- rt_val  in  XLEN  multiplier / divisor
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse; hi/lo valid from this cycle onward
- hi  out  XLEN  product upper half / remainder
- lo  out  XLEN  product lower half / quotient
- alu_ctl  out  4  ALU function code: 0010 add, 0110 sub, 1100 nor
- alu_a  out  XLEN  ALU operand A
- alu_b  out  XLEN  ALU operand B
- alu_out  in  XLEN  ALU result (combinational return)
- alu_zero  in  1  ALU zero flag
- alu_ovf  in  1  ALU overflow flag; ignored (unsigned carry is derived locally)

Behaviour:
- Reset: state=IDLE; busy=0, done=0, hi=0, lo=0, alu_ctl=0010, alu_a=0, alu_b=0; all internal working registers cleared. Reset mid-operation aborts immediately; no done is issued.
- Start acceptance: start=1 in IDLE at edge N latches op, rs_val and rt_val. start while busy is ignored; there is no queueing.
- States: IDLE -> ITER (XLEN cycles) -> DONE (1 cycle) -> IDLE.
- Latency: done=1 during cycle N+1+XLEN (N+33 at the default). A new start may be accepted in the cycle after DONE.
- Working registers: P_hi, P_lo, and counter cnt (0..XLEN-1). hi/lo hold their previous values until DONE loads P_hi/P_lo.
- Carry derivation, using a31/b31 = operand MSBs driven and s31 = alu_out[31]:
  - Add carry = (a31&b31) | ((a31|b31)&~s31).
  - Sub no-borrow = (a31&~b31) | ((a31|~b31)&~s31).
- MULTU:
  - Init: P_hi=0, P_lo=rs.
  - Each ITER cycle: alu_ctl=0010, alu_a=P_hi, alu_b=mcand.
  - If P_lo[0]=1: {P_hi,P_lo} <= {carry, alu_out, P_lo} >> 1.
  - Else: {P_hi,P_lo} <= {1'b0, P_hi, P_lo} >> 1.
- DIVU:
  - Init: P_hi=0, P_lo=rs.
  - Each ITER cycle: form shifted {msb, H', L'} = {P_hi,P_lo} << 1; alu_ctl=0110, alu_a=H', alu_b=divisor.
  - If msb | no-borrow: P_hi <= alu_out, P_lo <= {L'[XLEN-1:1], 1}.
  - Else: P_hi <= H', P_lo <= L'.
- Divide by zero (rt_val=0 on DIVU/DIV): ITER is skipped; DONE follows one cycle after acceptance with hi=rs_val, lo=all-ones. Latency 2.
- Counter: cnt increments each ITER cycle; ITER exits when cnt=XLEN-1. It wraps to 0 in DONE.
- alu_ctl/alu_a/alu_b are combinational from state and are held at 0010/0/0 in IDLE and DONE.

Optional Feature:
- Macro: MULDIV_SIGNED_EN.
- Enabled: op 10/11 become signed MULT/DIV with the flow IDLE -> PREP1 -> PREP2 -> ITER -> FIX1 -> FIX2 -> DONE. Latency is fixed at N+1+XLEN+4 (N+37) regardless of sign.
  - PREP1/PREP2: the ALU computes 0-rs and 0-rt (sub, alu_a=0). The magnitude is kept when the operand is negative.
  - MULT FIX1: P_lo <= 0-P_lo when signs differ; latch lo_was_zero = alu_zero.
  - MULT FIX2: P_hi <= lo_was_zero ? 0-P_hi : nor(P_hi,P_hi).
  - DIV: quotient is negated when signs differ; remainder is negated when the dividend is negative.
  - When no negation is required, FIX cycles still drive the ALU but do not write the working registers.
  - Divide by zero uses the raw operands and the 2-cycle path.
- Disabled: op[1] is ignored; 10 behaves as MULTU and 11 as DIVU.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> done at start+33; hi=0xFFFFFFFE, lo=0x00000001; alu_ctl=0010 on every ITER cycle.
- DIVU rs=100, rt=7 -> hi=2, lo=14 at start+33; busy high for exactly 33 cycles; start pulses during busy are ignored.
- DIVU rs=0x12345678, rt=0 -> done at start+2; hi=0x12345678, lo=0xFFFFFFFF.
- Reset asserted at ITER cycle 10 of MULTU 3x5 -> all outputs 0 immediately, no done; a fresh MULTU 3x5 gives hi=0, lo=15.
- MULDIV_SIGNED_EN: MULT -3 x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1 at start+37; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Back-to-back: start held high across DONE -> second op accepted in the cycle after DONE; hi/lo unchanged until the second done.
